cache_sa_wb: RTL
================

# cache_sa_wb

Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement. It sits between the CPU-side load/store port and the block-wide main memory model. It generalises the direct-mapped write-back cache by adding configurable geometry and associativity, an explicit request/done handshake, and a memory-side request/ready handshake that tolerates any memory latency. WAYS=1 degenerates to direct-mapped write-back behaviour.

## Interface
- ADDR_W, 10, word-address width
- DATA_W, 32, word width
- BLOCK_WORDS, 4, words per line (power of 2, ≥2)
- SETS, 4, sets (power of 2, ≥1)
- WAYS, 2, ways per set (power of 2, ≥1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpuReq  in  1  request strobe, sampled only when cpuBusy=0
- isRead  in  1  1=load, 0=store
- address  in  ADDR_W  word address
- writeData  in  DATA_W  store data
- cpuBusy  out  1  state≠IDLE
- cpuDone  out  1  one-cycle completion pulse
- readData  out  DATA_W  load result, valid while cpuDone=1, held until next completion
- isHit  out  1  1 if the request hit on first lookup, valid with cpuDone
- memReq  out  1  memory transaction active
- memWe  out  1  1=block write-back, 0=block fill
- memAddr  out  ADDR_W  block-aligned address (offset bits zero)
- memWdata  out  DATA_W*BLOCK_WORDS  victim line, word 0 in LSBs
- memRdata  in  DATA_W*BLOCK_WORDS  fill line, word 0 in LSBs
- memReady  in  1  one-cycle completion from memory

## Operation
- Address split: offset = low log2(BLOCK_WORDS) bits, index = next log2(SETS) bits, tag = remainder. Defaults: 2/2/6.
- Per line: valid, dirty, tag, data. Per set: log2(WAYS)-bit age per way (0 = MRU). Ages always form a permutation.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: cpuReq=1 latches isRead/address/writeData, clears missFlag → COMPARE.
- COMPARE, hit (valid && tag match in exactly one way): load returns word; store writes word, sets dirty. Hit way age←0, ways with smaller age +1. Registered cpuDone=1, isHit=!missFlag → IDLE.
- COMPARE, miss: set missFlag. Victim = lowest-index invalid way, else way with age WAYS-1. Victim dirty → WRITEBACK, else → ALLOCATE.
- WRITEBACK: memReq=1, memWe=1, memAddr={victim tag,index,0}, memWdata=victim line. On memReady → ALLOCATE.
- ALLOCATE: memReq=1, memWe=0, memAddr={tag,index,0}. On memReady load memRdata into victim, valid=1, dirty=0, tag written → COMPARE, which then hits and completes with isHit=0.
- Stores on miss: allocate, then merge the word in COMPARE (write-allocate); the line ends dirty.
- cpuReq while cpuBusy=1: ignored, not queued.
- memReady while memReq=0: ignored.

## Timing
- Reset values: state IDLE, cpuBusy=0, cpuDone=0, readData=0, isHit=0, memReq=0, memWe=0, memAddr=0, memWdata=0. All valid/dirty=0. Way w age=w. Data/tag arrays need not be cleared.
- Hit: accept edge E0, COMPARE during cycle 1, cpuDone high in the cycle after edge E1. Next request accepted at edge E2.
- Clean miss: memReq rises the cycle after COMPARE. cpuDone comes 2 cycles after the memReady edge.
- Dirty miss: write-back completes first. memReq drops for zero cycles between WRITEBACK and ALLOCATE; memWe changes 1→0 with memReq held.
- memAddr, memWe and memWdata stay stable while memReq=1.
- Reset mid-transaction: next edge returns to IDLE, memReq=0, all lines invalid. Dirty data is discarded without a flush; a pending memReady is ignored.
- isHit and readData hold their values after cpuDone drops.

## Test plan
Memory model responds with memReady 3 cycles after memReq, and initialises word a to a+0x3c00.

- Reset, then load 0x000 → clean miss, memReq with memWe=0, memAddr=0x000, cpuDone with isHit=0, readData=0x3c00. Reload 0x000 → isHit=1, done 2 cycles after accept.
- Store 0x000=0x000000ff (hit), load 0x000 → isHit=1, readData=0xff. Memory word 0x000 still 0x3c00 (write-back).
- Load 0x200, then load 0x000 → both in set 0 (2 ways), second is a hit. Load 0x300 → evicts LRU 0x200 (clean), no write-back.
- Load 0x100 → evicts dirty 0x000: memWe=1, memAddr=0x000, memWdata[31:0]=0xff, then fill 0x100. Memory word 0x000 becomes 0xff.
- Pulse cpuReq during a miss → ignored; exactly one cpuDone occurs.
- Assert reset while memReq=1 in WRITEBACK → memReq=0 and cpuBusy=0 next cycle. Load 0x000 afterwards misses.

Source files
------------

// File: rtl/cache_sa_wb.sv
// cache_sa_wb: N-way set-associative, write-back, write-allocate cache with
// true-LRU replacement between a CPU load/store port and a block-wide memory.
// Per-set ages form a permutation (0 = most recently used). A miss first writes
// back a dirty victim, then fills the line, and the request is re-run in COMPARE.
module cache_sa_wb #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 4,
  parameter int WAYS        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpuReq,
  input  logic                          isRead,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             writeData,
  output logic                          cpuBusy,
  output logic                          cpuDone,
  output logic [DATA_W-1:0]             readData,
  output logic                          isHit,
  output logic                          memReq,
  output logic                          memWe,
  output logic [ADDR_W-1:0]             memAddr,
  output logic [DATA_W*BLOCK_WORDS-1:0] memWdata,
  input  logic [DATA_W*BLOCK_WORDS-1:0] memRdata,
  input  logic                          memReady
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_B  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_B;
  localparam int SET_W  = (IDX_B > 0) ? IDX_B : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = DATA_W * BLOCK_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t r_state, w_next;

  logic              r_is_read;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_miss;
  logic [WAY_W-1:0]  r_victim;

  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [WAY_W-1:0]  r_age   [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [LINE_W-1:0] r_data  [SETS][WAYS];

  logic [OFF_W-1:0]  w_offset;
  logic [SET_W-1:0]  w_set;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_victim;
  logic              w_found_inv;
  logic [DATA_W-1:0] w_rd_word;

  assign w_offset = r_addr[OFF_W-1:0];
  assign w_set    = SET_W'((r_addr >> OFF_W) & ADDR_W'(SETS - 1));
  assign w_tag    = TAG_W'(r_addr >> (OFF_W + IDX_B));
  assign cpuBusy  = (r_state != S_IDLE);

  // Tag lookup and victim choice for the latched request's set.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_victim    = '0;
    w_found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found_inv && !r_valid[w_set][w]) begin
        w_found_inv = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
    if (!w_found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_set][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
      end
    end
    w_rd_word = r_data[w_set][w_hit_way][DATA_W*w_offset +: DATA_W];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and memory-side outputs (held stable by latched state).
  always_comb begin
    w_next   = r_state;
    memReq   = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    case (r_state)
      S_IDLE:    if (cpuReq) w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_hit)                        w_next = S_IDLE;
        else if (r_dirty[w_set][w_victim]) w_next = S_WRITEBACK;
        else                              w_next = S_ALLOCATE;
      end
      S_WRITEBACK: begin
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = (ADDR_W'(r_tag[w_set][r_victim]) << (OFF_W + IDX_B)) |
                   (ADDR_W'(w_set) << OFF_W);
        memWdata = r_data[w_set][r_victim];
        if (memReady) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        memReq  = 1'b1;
        memAddr = (ADDR_W'(w_tag) << (OFF_W + IDX_B)) | (ADDR_W'(w_set) << OFF_W);
        if (memReady) w_next = S_COMPARE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, completion outputs, line status bits and LRU ages.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpuDone   <= 1'b0;
      readData  <= '0;
      isHit     <= 1'b0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_miss    <= 1'b0;
      r_victim  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      cpuDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpuReq) begin
            r_is_read <= isRead;
            r_addr    <= address;
            r_wdata   <= writeData;
            r_miss    <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            cpuDone <= 1'b1;
            isHit   <= !r_miss;
            if (r_is_read) readData <= w_rd_word;
            else           r_dirty[w_set][w_hit_way] <= 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == w_hit_way)
                r_age[w_set][w] <= '0;
              else if (r_age[w_set][w] < r_age[w_set][w_hit_way])
                r_age[w_set][w] <= r_age[w_set][w] + 1'b1;
            end
          end else begin
            r_miss   <= 1'b1;
            r_victim <= w_victim;
          end
        end
        S_ALLOCATE: begin
          if (memReady) begin
            r_valid[w_set][r_victim] <= 1'b1;
            r_dirty[w_set][r_victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: no reset, contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_COMPARE && w_hit && !r_is_read)
        r_data[w_set][w_hit_way][DATA_W*w_offset +: DATA_W] <= r_wdata;
      if (r_state == S_ALLOCATE && memReady) begin
        r_data[w_set][r_victim] <= memRdata;
        r_tag[w_set][r_victim]  <= w_tag;
      end
    end
  end

endmodule
